// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample majority vote, runtime frame format,
// error/break detection and a small valid/ready receive FIFO.
module uart_rx_ovs #(
  parameter int DIV_W      = 16,
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic [1:0]       data_bits_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             stop2_i,
  input  logic             rx_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_perr_o,
  output logic             rx_ferr_o,
  output logic             rx_brk_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             overrun_o,
  output logic             busy_o
);
  localparam int OW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [OW-1:0] T_S0  = OW'(OSR/2 - 2);
  localparam logic [OW-1:0] T_S1  = OW'(OSR/2 - 1);
  localparam logic [OW-1:0] T_MID = OW'(OSR/2);
  localparam logic [OW-1:0] T_END = OW'(OSR - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH, S_WAIT
  } state_e;

  logic             sync_q, rxs_q, rxs_prev_q;
  state_e           state_q;
  logic [DIV_W-1:0] div_q, div_cnt_q;
  logic [OW-1:0]    ostk_q;
  logic             s0_q, s1_q;
  logic [1:0]       dbits_q;
  logic             pen_q, podd_q, stop2_q;
  logic [2:0]       bcnt_q;
  logic [7:0]       data_q;
  logic             par_q, zero_q, perr_q, ferr_q, brk_q;

  logic             fall, tick, mtick, maj;
  logic [2:0]       last_bit;

  assign fall     = rxs_prev_q & ~rxs_q;
  assign tick     = (state_q != S_IDLE) && (div_cnt_q == div_q);
  assign mtick    = tick && (ostk_q == T_MID);
  assign maj      = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign last_bit = {1'b0, dbits_q} + 3'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= rx_i;
      rxs_q      <= sync_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Frame FSM; every bit decision is taken on the mid-bit majority tick, so
  // PUSH lands in the middle of the last stop bit and the next start can follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      div_cnt_q <= '0;
      ostk_q    <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      dbits_q   <= '0;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      stop2_q   <= 1'b0;
      bcnt_q    <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      zero_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE)  div_cnt_q <= '0;
      else if (tick)          div_cnt_q <= '0;
      else                    div_cnt_q <= div_cnt_q + 1'b1;

      if (state_q == S_IDLE)  ostk_q <= '0;
      else if (tick)          ostk_q <= (ostk_q == T_END) ? '0 : ostk_q + 1'b1;

      if (tick && ostk_q == T_S0) s0_q <= rxs_q;
      if (tick && ostk_q == T_S1) s1_q <= rxs_q;

      case (state_q)
        S_IDLE: if (fall) begin
          state_q <= S_START;
          div_q   <= baud_div_i;
          dbits_q <= data_bits_i;
          pen_q   <= parity_en_i;
          podd_q  <= parity_odd_i;
          stop2_q <= stop2_i;
          bcnt_q  <= '0;
          data_q  <= '0;
          par_q   <= 1'b0;
          zero_q  <= 1'b1;
          perr_q  <= 1'b0;
          ferr_q  <= 1'b0;
          brk_q   <= 1'b0;
        end
        S_START: if (mtick) state_q <= maj ? S_IDLE : S_DATA;
        S_DATA: if (mtick) begin
          data_q[bcnt_q] <= maj;
          par_q          <= par_q ^ maj;
          zero_q         <= zero_q & ~maj;
          bcnt_q         <= bcnt_q + 1'b1;
          if (bcnt_q == last_bit) state_q <= pen_q ? S_PARITY : S_STOP1;
        end
        S_PARITY: if (mtick) begin
          perr_q  <= par_q ^ maj ^ podd_q;
          zero_q  <= zero_q & ~maj;
          state_q <= S_STOP1;
        end
        S_STOP1: if (mtick) begin
          ferr_q  <= ~maj;
          brk_q   <= zero_q & ~maj;
          state_q <= stop2_q ? S_STOP2 : S_PUSH;
        end
        S_STOP2: if (mtick) begin
          ferr_q  <= ferr_q | ~maj;
          state_q <= S_PUSH;
        end
        S_PUSH:  state_q <= ferr_q ? S_WAIT : S_IDLE;
        S_WAIT:  if (rxs_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [FIFO_DEPTH-1:0][10:0] mem_q;
  logic [AW-1:0]               wptr_q, rptr_q;
  logic [AW:0]                 cnt_q;
  logic                        ovr_q;
  logic                        push, pop, full, wr_en;

  assign push  = (state_q == S_PUSH);
  assign pop   = (cnt_q != '0) && rx_ready_i;
  assign full  = (cnt_q == FULL_CNT);
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= push && full && !pop;
      if (wr_en) begin
        mem_q[wptr_q] <= {brk_q, ferr_q, perr_q, data_q};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (wr_en && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rx_data_o  = mem_q[rptr_q][7:0];
  assign rx_perr_o  = mem_q[rptr_q][8];
  assign rx_ferr_o  = mem_q[rptr_q][9];
  assign rx_brk_o   = mem_q[rptr_q][10];
  assign rx_valid_o = (cnt_q != '0);
  assign overrun_o  = ovr_q;
  assign busy_o     = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: frames are bit-banged on rx_i and popped
// entries are compared against hand-computed {brk,ferr,perr,data} values.
module tb_uart_rx_ovs;
  localparam int BIT = 64;  // OSR 16 * (baud_div 3 + 1)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic [1:0]  data_bits = 2'd3;
  logic        parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic        rx = 1'b1;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_brk, rx_valid, overrun, busy;

  uart_rx_ovs #(.DIV_W(16), .OSR(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div_i(baud_div), .data_bits_i(data_bits),
    .parity_en_i(parity_en), .parity_odd_i(parity_odd), .stop2_i(stop2),
    .rx_i(rx), .rx_data_o(rx_data), .rx_perr_o(rx_perr), .rx_ferr_o(rx_ferr),
    .rx_brk_o(rx_brk), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .overrun_o(overrun), .busy_o(busy)
  );

  always #5 clk = ~clk;

  logic [10:0] rec[$];
  int vcnt = 0, ocnt = 0;
  int nchk = 0, npass = 0, nfail = 0, rd = 0;

  always @(negedge clk) begin
    if (rx_valid) vcnt++;
    if (rx_valid && rx_ready) rec.push_back({rx_brk, rx_ferr, rx_perr, rx_data});
    if (overrun) ocnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input logic [10:0] exp);
    if (rd < rec.size()) begin
      check(tag, 32'(rec[rd]), 32'(exp));
      rd++;
    end else check({tag, ".present"}, 32'd0, 32'd1);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Leaves the line at the last driven level; caller restores idle.
  task automatic send(input logic [7:0] d, input int nd, input bit pen, input bit pbit,
                      input bit s1, input bit has2, input bit s2);
    drive_bit(1'b0);
    for (int i = 0; i < nd; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(s1);
    if (has2) drive_bit(s2);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1 rx_ready = r;
  endtask

  task automatic cfg(input logic [1:0] db, input bit pe, input bit po, input bit s2);
    data_bits = db; parity_en = pe; parity_odd = po; stop2 = s2;
  endtask

  int v0, o0, n0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst.valid", 32'(rx_valid), 32'd0);
    check("rst.data", 32'(rx_data), 32'd0);
    check("rst.flags", 32'({rx_perr, rx_ferr, rx_brk, overrun, busy}), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // 8N1 0xA5
    cfg(2'd3, 0, 0, 0);
    v0 = vcnt;
    send(8'hA5, 8, 0, 0, 1, 0, 0);
    idle(2*BIT);
    chk_entry("8n1.a5", 11'h0A5);
    check("8n1.valid_cycles", 32'(vcnt - v0), 32'd1);
    check("8n1.busy_idle", 32'(busy), 32'd0);

    // 7O1 0x41: two ones so the correct odd parity bit is 1
    cfg(2'd2, 1, 1, 0);
    send(8'h41, 7, 1, 0, 1, 0, 0);
    idle(2*BIT);
    chk_entry("7o1.badpar", 11'h141);
    send(8'h41, 7, 1, 1, 1, 0, 0);
    idle(2*BIT);
    chk_entry("7o1.goodpar", 11'h041);

    // false start: 5-tick low glitch
    cfg(2'd3, 0, 0, 0);
    n0 = rec.size();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch.busy", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch.busy_clear", 32'(busy), 32'd0);
    idle(2*BIT);
    check("glitch.no_push", 32'(rec.size() - n0), 32'd0);
    send(8'h3C, 8, 0, 0, 1, 0, 0);
    idle(2*BIT);
    chk_entry("glitch.3c", 11'h03C);

    // 8N2 with a low second stop bit
    cfg(2'd3, 0, 0, 1);
    send(8'h5A, 8, 0, 0, 1, 1, 0);
    drive_bit(1'b0);
    chk_entry("8n2.ferr", 11'h25A);
    check("8n2.wait_high", 32'(busy), 32'd1);
    idle(10);
    check("8n2.released", 32'(busy), 32'd0);
    send(8'h11, 8, 0, 0, 1, 1, 1);
    idle(2*BIT);
    chk_entry("8n2.11", 11'h011);

    // 8E1 break: line low for 15 bit times
    cfg(2'd3, 1, 0, 0);
    n0 = rec.size();
    rx = 1'b0;
    repeat (15*BIT) @(negedge clk);
    check("brk.count", 32'(rec.size() - n0), 32'd1);
    chk_entry("brk.entry", 11'h600);
    check("brk.wait_high", 32'(busy), 32'd1);
    idle(2*BIT);
    check("brk.no_more", 32'(rec.size() - n0), 32'd1);
    send(8'h81, 8, 1, 0, 1, 0, 0);
    idle(2*BIT);
    chk_entry("brk.next81", 11'h081);

    // overrun with the consumer stalled
    cfg(2'd3, 0, 0, 0);
    set_ready(1'b0);
    o0 = ocnt;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 8, 0, 0, 1, 0, 0);
      idle(BIT);
    end
    check("ovr.pulses", 32'(ocnt - o0), 32'd1);
    check("ovr.valid", 32'(rx_valid), 32'd1);
    check("ovr.head", 32'(rx_data), 32'h01);
    set_ready(1'b1);
    repeat (10) @(negedge clk);
    chk_entry("ovr.d1", 11'h001);
    chk_entry("ovr.d2", 11'h002);
    chk_entry("ovr.d3", 11'h003);
    chk_entry("ovr.d4", 11'h004);
    check("ovr.drained", 32'(rx_valid), 32'd0);
    check("ovr.no_extra", 32'(rec.size() - rd), 32'd0);

    // reset in the middle of 0x06 with one entry held
    set_ready(1'b0);
    send(8'h33, 8, 0, 0, 1, 0, 0);
    idle(BIT);
    check("mrst.pre_valid", 32'(rx_valid), 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst.valid", 32'(rx_valid), 32'd0);
    check("mrst.data", 32'(rx_data), 32'd0);
    check("mrst.flags", 32'({rx_perr, rx_ferr, rx_brk, overrun, busy}), 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    idle(20);
    send(8'h07, 8, 0, 0, 1, 0, 0);
    idle(2*BIT);
    chk_entry("mrst.07", 11'h007);
    check("mrst.no_extra", 32'(rec.size() - rd), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
Parametrised successor UART receiver: programmable integer baud divisor, OSR-times oversampling with 3-sample majority vote per bit, and runtime-selectable frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits). It detects false starts, parity errors, framing errors and breaks. Received characters plus status go into a small FIFO drained through a valid/ready interface by the AXI-lite/DMA side of the design.

Parameters:
DIV_W, 16, width of baud_div_i.
OSR, 16, oversampling ticks per bit. Must be even and ≥ 6.
FIFO_DEPTH, 4, receive FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
baud_div_i  in  DIV_W  tick period minus 1 (tick every baud_div_i+1 clk)
data_bits_i  in  2  0:5 bits, 1:6, 2:7, 3:8
parity_en_i  in  1  1: parity bit present
parity_odd_i  in  1  1: odd parity, 0: even parity
stop2_i  in  1  1: two stop bits
rx_i  in  1  asynchronous serial line, idle high
rx_data_o  out  8  received character, LSB-aligned, unused upper bits 0
rx_perr_o  out  1  parity error flag of head entry
rx_ferr_o  out  1  framing error flag of head entry
rx_brk_o  out  1  break flag of head entry
rx_valid_o  out  1  FIFO head valid
rx_ready_i  in  1  consumer accepts head entry
overrun_o  out  1  one-cycle pulse when a completed frame is dropped
busy_o  out  1  receiver not in IDLE

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs reset to 0. The synchroniser resets to 1. The FIFO is emptied. The FSM enters IDLE.
- rx_i passes through a 2-FF synchroniser. All logic uses the synchronised value (rxs).
- Tick generator:
  - Counter is held at 0 in IDLE.
  - Otherwise it counts 0..baud_div_i. A tick fires when count==baud_div_i, then the counter wraps to 0.
  - A tick counter (0..OSR-1) advances per tick. One bit period = OSR ticks.
- Bit sampling:
  - rxs is sampled at ticks OSR/2-2, OSR/2-1 and OSR/2 of each bit.
  - The bit value is the majority of the 3 samples, evaluated on the last of the three ticks.
- Config latch: baud_div_i, data_bits_i, parity_en_i, parity_odd_i and stop2_i are latched on start detection. Changes mid-frame have no effect.
- FSM:
  - IDLE → START on a falling edge of rxs (previous 1, current 0). busy_o=1 from the next cycle.
  - START: if the majority is 1, it is a false start; return to IDLE and push nothing. Otherwise go to DATA.
  - DATA: shift in N=data_bits_i+5 bits, LSB first. After bit N, go to PARITY if parity_en, else STOP1.
  - PARITY: perr = (XOR of data bits XOR parity bit XOR parity_odd) != 0.
  - STOP1: ferr set if the majority is 0. Go to STOP2 if stop2, else PUSH.
  - STOP2: ferr |= (majority == 0).
  - PUSH: a one-cycle state. Write {brk, ferr, perr, data} into the FIFO.
    - If ferr=1, go to WAIT_HIGH; otherwise go to IDLE.
    - The next start can be detected from the cycle after PUSH (mid-stop resync).
  - WAIT_HIGH: remain until rxs==1, then go to IDLE. A held-low line does not retrigger.
- Break: brk=1 when all data bits, the parity bit (if present) and the first stop bit are 0. brk implies ferr=1.
- FIFO:
  - Registered outputs. rx_valid_o=1 when not empty. A pop happens when rx_valid_o && rx_ready_i.
  - An entry pushed in PUSH appears on the outputs no later than 1 cycle after PUSH when the FIFO was empty (rx_valid_o rises at PUSH+1).
  - Simultaneous push and pop is legal at any occupancy, including full: both happen and the occupancy is unchanged.
  - A push when full and not popping drops the new frame. overrun_o pulses for 1 cycle. Stored entries are untouched.
  - Pointers wrap modulo FIFO_DEPTH. An occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-frame: the frame is discarded and the FIFO is cleared. After release, the first falling edge starts a new frame.

Test Plan:
- 8N1, baud_div_i=3, OSR=16, rx_ready_i=1, send 0xA5 → one entry: rx_data_o=0xA5, perr=ferr=brk=0. rx_valid_o high for exactly 1 cycle.
- 7O1 (data_bits_i=2, parity_en=1, parity_odd=1), send 0x41 with a wrong parity bit → rx_data_o=0x41, rx_perr_o=1. Same frame with the correct parity → perr=0.
- Low glitch of 5 ticks on idle line → no push, busy_o returns to 0 by mid start bit. Then a valid 0x3C → rx_data_o=0x3C.
- 8N2, send 0x5A with the second stop bit low → ferr=1, brk=0. The FSM waits in WAIT_HIGH until the line rises, then 0x11 → 0x11 with ferr=0.
- 8E1 line held low for 15 bit times → one entry with rx_data_o=0x00, brk=1, ferr=1. No further entries until the line goes high and a new start bit arrives.
- rx_ready_i=0, FIFO_DEPTH=4, send 0x01..0x05 → 5th frame dropped, overrun_o pulses once. Drain yields 0x01..0x04 in order. Assert rst_n low mid-frame on 0x06 → outputs 0, FIFO empty.
